frame_burst_writer: RTL
=======================

// Module: frame_burst_writer
// PURPOSE
// - Upstream feeder for the DDR3 memory interface of the instrument unit system.
// - Takes a pixel/sample stream (valid/ready + start-of-frame), buffers it in an internal FIFO,
//   and writes each frame to DDR at base_addr as fixed-length Avalon-MM write bursts.
// - Pulses frame_done once the last word of a frame has been accepted by the memory side.
// PARAMETERS
// - DATA_W       32       stream and Avalon write data width, bits (multiple of 8)
// - ADDR_W       32       Avalon byte address width
// - BURST_LEN    8        words per full burst (power of 2, 1..64)
// - FIFO_DEPTH   32       FIFO entries (power of 2, >= 2*BURST_LEN)
// - FRAME_WORDS  307200   words per frame (640x480); final burst may be short
// PORTS
// - clk_clk          in   1              single clock, all logic rising-edge
// - reset_reset_n    in   1              reset, synchronous, active-low
// - enable           in   1              level; 1 = capture frames
// - base_addr        in   ADDR_W         frame byte address, sampled when state leaves WAIT_SOF
// - in_data          in   DATA_W         stream word
// - in_valid         in   1              in_data valid
// - in_sof           in   1              qualifies first word of a frame (valid only with in_valid)
// - in_ready         out  1              word accepted when in_valid & in_ready
// - avm_address      out  ADDR_W         burst start byte address
// - avm_write        out  1              write request
// - avm_writedata    out  DATA_W         write data
// - avm_burstcount   out  7              words in current burst
// - avm_waitrequest  in   1              slave stall
// - busy             out  1              state != IDLE
// - frame_done       out  1              one-cycle pulse, frame fully written
// BEHAVIOUR
// - Reset: state=IDLE, FIFO empty, all outputs 0 (in_ready=0, avm_write=0, counters 0).
// - FSM: IDLE -(enable)-> WAIT_SOF -(in_valid&in_sof&in_ready)-> CAPTURE -(all FRAME_WORDS issued)-> DONE -> WAIT_SOF
//   (or IDLE if enable=0). DONE lasts 1 cycle and drives frame_done=1.
// - WAIT_SOF: in_ready=1, words without in_sof are dropped; SOF word enters FIFO, base_addr latched.
// - CAPTURE: in_ready = !fifo_full & (words_accepted < FRAME_WORDS); in_sof on later words ignored.
// - Burst issue: when no burst active and fifo_count >= min(BURST_LEN, words_remaining_to_issue),
//   assert avm_write with avm_address, avm_burstcount constant for the whole burst.
// - Beat handshake: beat completes on avm_write & !avm_waitrequest; FIFO pops same cycle; writedata
//   = FIFO head (show-ahead, 0-cycle read). avm_write stays high through all beats of a burst.
// - After last beat: avm_write=0 for >= 1 cycle; avm_address += burstcount*(DATA_W/8), wraps mod 2^ADDR_W.
// - Latency: first avm_write no earlier than 1 cycle after BURST_LEN-th word is accepted.
// - FIFO: simultaneous push and pop legal at full and empty; count unchanged on push+pop.
// - enable falls mid-frame: stop accepting (in_ready=0), finish the active burst, flush FIFO,
//   go IDLE, no frame_done.
// - Reset mid-burst: avm_write drops next edge; burst abandoned (memory side reset together).
// - frame_done asserted only after final beat handshake of word FRAME_WORDS.
// CONFIGURATION
// - FBW_STALL_CNT_EN defined: adds output stall_cnt [15:0], counts cycles with in_valid & !in_ready
//   in CAPTURE; saturates at 16'hFFFF; cleared on reset and on WAIT_SOF->CAPTURE.
// - Undefined: no stall_cnt port or logic; all other behaviour identical.
// TESTING
// - Reset: hold reset_reset_n=0 4 cycles with random inputs -> all outputs 0, busy=0.
// - FRAME_WORDS=20, BURST_LEN=8, no stalls, base_addr=0x1000 -> bursts at 0x1000/8, 0x1020/8, 0x1040/4 words,
//   data ramp 0..19 in order, single frame_done.
// - Words before SOF (5 junk) then SOF frame -> junk never written; first beat data = SOF word.
// - avm_waitrequest random 50% -> avm_address/burstcount stable in burst, no beat lost or duplicated.
// - Source bursts faster than sink (waitrequest held 40 cycles) -> FIFO fills to 32, in_ready=0, no loss;
//   with FBW_STALL_CNT_EN stall_cnt equals counted stall cycles.
// - enable=0 after 10 words -> active burst completes, no frame_done, busy=0, next frame restarts at base_addr.

Source files
------------

// File: rtl/frame_burst_writer.sv
// frame_burst_writer: buffers a framed stream in a show-ahead FIFO and writes it to memory as Avalon-MM bursts
// Define FBW_STALL_CNT_EN to add the stall_cnt output counting input stalls during capture.
module frame_burst_writer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 32,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [6:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              frame_done
`ifdef FBW_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp_q, wp_d, rp_q, rp_d, cnt;
  logic [CW-1:0] acc_q, acc_d, iss_q, iss_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0] bc_q, bc_d, brem_q, brem_d;
  logic bact_q, bact_d, full, push, pop, last;
  logic [31:0] rem, need;
  always_comb begin
    cnt = wp_q - rp_q;
    full = cnt == (PW+1)'(FIFO_DEPTH);
    rem = 32'(FRAME_WORDS) - 32'(iss_q);
    need = rem > 32'(BURST_LEN) ? 32'(BURST_LEN) : rem;
    pop = bact_q & !avm_waitrequest;
    last = pop & (brem_q == 7'd1);
    in_ready = (state_q == WAIT_SOF) | (state_q == CAPTURE & !full & 32'(acc_q) < 32'(FRAME_WORDS));
    push = in_valid & in_ready & (state_q == CAPTURE | in_sof);
    state_d = state_q;
    wp_d = wp_q + (PW+1)'(push);
    rp_d = rp_q + (PW+1)'(pop);
    acc_d = acc_q + CW'(push);
    iss_d = iss_q + CW'(pop);
    addr_d = last ? addr_q + ADDR_W'(32'(bc_q) * (DATA_W / 8)) : addr_q;
    bc_d = bc_q;
    brem_d = brem_q - 7'(pop);
    bact_d = bact_q & !last;
    case (state_q)
      IDLE: state_d = enable ? WAIT_SOF : IDLE;
      WAIT_SOF: begin
        if (!enable) state_d = IDLE;
        else if (push) begin
          state_d = CAPTURE;
          acc_d = CW'(1);
          iss_d = '0;
          addr_d = base_addr;
        end
      end
      CAPTURE: begin
        if (!bact_q & rem != 0 & 32'(cnt) >= need) begin
          bact_d = 1'b1;
          bc_d = 7'(need);
          brem_d = 7'(need);
        end
        if (pop & 32'(iss_q) == 32'(FRAME_WORDS - 1)) state_d = DONE;
        else if (!enable) state_d = FLUSH;
      end
      FLUSH: begin
        // the active burst drains normally; leftover words are discarded once it ends
        if (!bact_q) begin
          state_d = IDLE;
          wp_d = '0;
          rp_d = '0;
        end
      end
      DONE: state_d = enable ? WAIT_SOF : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      acc_q <= '0;
      iss_q <= '0;
      addr_q <= '0;
      bc_q <= '0;
      brem_q <= '0;
      bact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      acc_q <= acc_d;
      iss_q <= iss_d;
      addr_q <= addr_d;
      bc_q <= bc_d;
      brem_q <= brem_d;
      bact_q <= bact_d;
    end
  end
  always_ff @(posedge clk_clk) if (push) mem[wp_q[PW-1:0]] <= in_data;
  assign avm_write = bact_q;
  assign avm_address = addr_q;
  assign avm_burstcount = bc_q;
  assign avm_writedata = bact_q ? mem[rp_q[PW-1:0]] : '0;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
`ifdef FBW_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (state_q == WAIT_SOF & push) ? '0 :
                        (state_q == CAPTURE & in_valid & !in_ready & stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk_clk) stall_q <= !reset_reset_n ? '0 : stall_d;
  assign stall_cnt = stall_q;
`endif
endmodule
